bg_scan_driver: RTL and testbench

- Raster scan generator that drives the background filler's request side (x, y, enable) and consumes its returned palette index.
- Produces latency-aligned pixel index, hsync, vsync and blank toward the palette/DAC stage.
- Sits between the pixel-clock domain timing and the background fill path in the gpu.
- Hides the filler's pipeline latency from the display output.

---
 rtl/bg_scan_driver_if.sv | 36 +++
 rtl/bg_scan_driver.sv | 121 ++++++++++++
 tb/tb_bg_scan_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_scan_driver_if.sv
// Background-scan bus: filler request/return plus the aligned display outputs.
// Ports: fill_enable/fill_x/fill_y (request), fill_index (filler return),
//        pix_index/hsync/vsync/blank/frame_start (toward palette/DAC stage).
// Optional BG_SCAN_BORDER_EN adds border_index, the palette index shown in blank.
interface bg_scan_driver_if;
  logic       fill_enable;
  logic [9:0] fill_x;
  logic [9:0] fill_y;
  logic [8:0] fill_index;
  logic [8:0] pix_index;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic       frame_start;
`ifdef BG_SCAN_BORDER_EN
  logic [8:0] border_index;
`endif

  // Scan driver side.
  modport master (
    output fill_enable, fill_x, fill_y, pix_index, hsync, vsync, blank, frame_start,
`ifdef BG_SCAN_BORDER_EN
    input  border_index,
`endif
    input  fill_index
  );

  // Filler / palette side.
  modport slave (
    input  fill_enable, fill_x, fill_y, pix_index, hsync, vsync, blank, frame_start,
`ifdef BG_SCAN_BORDER_EN
    output border_index,
`endif
    output fill_index
  );
endinterface

// File: rtl/bg_scan_driver.sv
// Raster scan generator feeding the background filler and realigning its result with syncs.
// Latency: request 1 pix_ce step after the counters; outputs FILL_LAT+1 steps after the request.
// Backpressure: none; every stage advances only on pix_ce, the filler must keep pace.
// Ports: clk, reset (async, active-high), pix_ce (pixel advance strobe), bus (master modport):
//   fill_enable/fill_x/fill_y out, fill_index in, pix_index/hsync/vsync/blank/frame_start out.
// Optional feature macro BG_SCAN_BORDER_EN: blank pixels show bus.border_index instead of 0.
// FILL_LAT must be 1..4 and match the filler's latency in pix_ce steps.
module bg_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FILL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  bg_scan_driver_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Per-pixel timing that must travel alongside the filler's latency.
  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
    logic first;   // pixel (0,0) of the frame
  } align_t;

  localparam align_t ALIGN_IDLE = '{blank: 1'b1, hsync: 1'b1, vsync: 1'b1, first: 1'b0};

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  align_t     raw;
  align_t     pipe [FILL_LAT];
  logic [8:0] blank_fill;

`ifdef BG_SCAN_BORDER_EN
  assign blank_fill = bus.border_index;
`else
  assign blank_fill = 9'd0;
`endif

  // Counters and request stage. The request registers hold the counter value
  // of the previous step, so they and the raw timing below describe the same pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      bus.fill_x      <= '0;
      bus.fill_y      <= '0;
      bus.fill_enable <= 1'b0;
    end else if (pix_ce) begin
      bus.fill_x      <= h_cnt;
      bus.fill_y      <= v_cnt;
      bus.fill_enable <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Raw timing is derived from the registered request so it enters the
  // alignment pipe on the same step the filler receives that pixel.
  // The first flag needs fill_enable: the post-reset request is also (0,0).
  always_comb begin
    raw       = ALIGN_IDLE;
    raw.blank = ~bus.fill_enable;
    raw.hsync = ~((bus.fill_x >= HS_BEG) && (bus.fill_x < HS_END));
    raw.vsync = ~((bus.fill_y >= VS_BEG) && (bus.fill_y < VS_END));
    raw.first = bus.fill_enable && (bus.fill_x == '0) && (bus.fill_y == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FILL_LAT; i++) pipe[i] <= ALIGN_IDLE;
    end else if (pix_ce) begin
      pipe[0] <= raw;
      for (int i = 1; i < FILL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Output stage: pipe tail and fill_index now describe the same pixel.
  // frame_start is qualified by pix_ce so it stays one clk wide at any strobe rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pix_index   <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank       <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= pix_ce && pipe[FILL_LAT-1].first;
      if (pix_ce) begin
        bus.pix_index <= pipe[FILL_LAT-1].blank ? blank_fill : bus.fill_index;
        bus.hsync     <= pipe[FILL_LAT-1].hsync;
        bus.vsync     <= pipe[FILL_LAT-1].vsync;
        bus.blank     <= pipe[FILL_LAT-1].blank;
      end
    end
  end

endmodule

// File: tb/tb_bg_scan_driver.sv
// Bench for bg_scan_driver: three instances (default timing FILL_LAT=1 and 3,
// plus a tiny raster with FILL_LAT=2 so whole frames fit in a short run).
// Expected values come from pixel-position arithmetic on the pix_ce step count.
module tb_bg_scan_driver;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;
  logic done;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

`ifdef BG_SCAN_BORDER_EN
  localparam logic [8:0] BLANK_PIX = 9'h1A5;
`else
  localparam logic [8:0] BLANK_PIX = 9'h000;
`endif

  localparam int P_HA [3] = '{640, 640, 8};
  localparam int P_HF [3] = '{16, 16, 2};
  localparam int P_HS [3] = '{96, 96, 3};
  localparam int P_HB [3] = '{48, 48, 2};
  localparam int P_VA [3] = '{480, 480, 4};
  localparam int P_VF [3] = '{10, 10, 1};
  localparam int P_VS [3] = '{2, 2, 2};
  localparam int P_VB [3] = '{33, 33, 1};
  localparam int P_L  [3] = '{1, 3, 2};

  typedef struct {
    int         k;
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] pix;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int HA = P_HA[g];
    localparam int HF = P_HF[g];
    localparam int HS = P_HS[g];
    localparam int VA = P_VA[g];
    localparam int VF = P_VF[g];
    localparam int VS = P_VS[g];
    localparam int L  = P_L[g];
    localparam int HT = HA + HF + HS + P_HB[g];
    localparam int VT = VA + VF + VS + P_VB[g];

    bg_scan_driver_if bus();

    bg_scan_driver #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(P_HB[g]),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(P_VB[g]),
      .FILL_LAT(L)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .pix_ce(pix_ce),
      .bus   (bus)
    );

    // Filler model: returns fill_x[8:0] exactly L pix_ce steps after the request.
    logic [8:0] dl [L];
    assign bus.fill_index = dl[L-1];
`ifdef BG_SCAN_BORDER_EN
    assign bus.border_index = BLANK_PIX;
`endif

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < L; i++) dl[i] <= 9'd0;
      end else if (pix_ce) begin
        dl[0] <= bus.fill_x[8:0];
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
      end
    end

    // State after the k-th pix_ce edge since reset: the request shows scan
    // position k-1, the outputs show position k-2-L.
    function automatic exp_t exp_at(input int k);
      exp_t e;
      int   h;
      int   v;
      int   m;
      e = '{k: k, en: 1'b0, x: 10'd0, y: 10'd0, pix: 9'd0,
            hs: 1'b1, vs: 1'b1, bl: 1'b1, fs: 1'b0};
      if (k >= 1) begin
        h     = (k - 1) % HT;
        v     = ((k - 1) / HT) % VT;
        e.x   = 10'(h);
        e.y   = 10'(v);
        e.en  = (h < HA) && (v < VA);
        e.pix = BLANK_PIX;
      end
      m = k - 2 - L;
      if (m >= 0) begin
        h     = m % HT;
        v     = (m / HT) % VT;
        e.bl  = !((h < HA) && (v < VA));
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.pix = e.bl ? BLANK_PIX : 9'(h);
        e.fs  = (h == 0) && (v == 0);
      end
      return e;
    endfunction

    exp_t q[$];
    exp_t last;
    exp_t e;
    int   n_step;
    logic ce_seen;
    int   fs_k, hs_fall, vs_fall;
    logic prev_hs, prev_vs, first_hs, first_vs;

    // Stimulus side of the scoreboard: each pix_ce edge queues its expectation.
    initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        n_step  = 0;
        ce_seen = 1'b0;
        q.delete();
      end else begin
        ce_seen = pix_ce;
        if (pix_ce) begin
          n_step++;
          q.push_back(exp_at(n_step));
        end
      end
    end

    // Monitor: compares on the falling edge, away from the DUT's active edge.
    initial forever begin
      @(negedge clk);
      if (reset) begin
        last = exp_at(0);
        check($sformatf("i%0d rst", g),
              64'({bus.fill_enable, bus.fill_x, bus.fill_y, bus.pix_index,
                   bus.hsync, bus.vsync, bus.blank, bus.frame_start}),
              64'({last.en, last.x, last.y, last.pix, last.hs, last.vs, last.bl, last.fs}));
        fs_k = -1; hs_fall = -1; vs_fall = -1;
        prev_hs = 1'b1; prev_vs = 1'b1; first_hs = 1'b0; first_vs = 1'b0;
      end else if (!ce_seen) begin
        check($sformatf("i%0d hold", g),
              64'({bus.fill_enable, bus.fill_x, bus.fill_y, bus.pix_index,
                   bus.hsync, bus.vsync, bus.blank, bus.frame_start}),
              64'({last.en, last.x, last.y, last.pix, last.hs, last.vs, last.bl, 1'b0}));
      end else if (q.size() == 0) begin
        n_total++;
        $display("FAIL i%0d queue: DUT stepped with no expectation queued", g);
      end else begin
        e = q.pop_front();
        last = e;
        check($sformatf("i%0d req k=%0d {en,x,y}", g, e.k),
              64'({bus.fill_enable, bus.fill_x, bus.fill_y}),
              64'({e.en, e.x, e.y}));
        check($sformatf("i%0d out k=%0d {pix,hs,vs,bl,fs}", g, e.k),
              64'({bus.pix_index, bus.hsync, bus.vsync, bus.blank, bus.frame_start}),
              64'({e.pix, e.hs, e.vs, e.bl, e.fs}));
        // Sync timing measured against the raster constants.
        if (bus.frame_start) begin
          if (fs_k >= 0) check($sformatf("i%0d fs_period", g), 64'(e.k - fs_k), 64'(HT * VT));
          fs_k = e.k; first_hs = 1'b1; first_vs = 1'b1;
        end
        if (prev_hs && !bus.hsync) begin
          if (first_hs) check($sformatf("i%0d hs_ofs", g), 64'(e.k - fs_k), 64'(HA + HF));
          if (hs_fall >= 0) check($sformatf("i%0d hs_period", g), 64'(e.k - hs_fall), 64'(HT));
          hs_fall = e.k; first_hs = 1'b0;
        end
        if (!prev_hs && bus.hsync && hs_fall >= 0)
          check($sformatf("i%0d hs_width", g), 64'(e.k - hs_fall), 64'(HS));
        if (prev_vs && !bus.vsync) begin
          if (first_vs) check($sformatf("i%0d vs_ofs", g), 64'(e.k - fs_k), 64'((VA + VF) * HT));
          if (vs_fall >= 0) check($sformatf("i%0d vs_period", g), 64'(e.k - vs_fall), 64'(HT * VT));
          vs_fall = e.k; first_vs = 1'b0;
        end
        if (!prev_vs && bus.vsync && vs_fall >= 0)
          check($sformatf("i%0d vs_width", g), 64'(e.k - vs_fall), 64'(VS * HT));
        prev_hs = bus.hsync;
        prev_vs = bus.vsync;
      end
    end

    // Reset must take effect before any clock edge.
    initial forever begin
      @(posedge reset);
      #1;
      check($sformatf("i%0d arst", g),
            64'({bus.fill_enable, bus.fill_x, bus.fill_y, bus.pix_index,
                 bus.hsync, bus.vsync, bus.blank, bus.frame_start}),
            64'({1'b0, 10'd0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    end

    initial begin
      @(posedge done);
      check($sformatf("i%0d drain", g), 64'(q.size()), 64'd0);
    end
  end

  initial begin
    done   = 1'b0;
    reset  = 1'b1;
    pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Continuous pix_ce: two full default lines, many tiny frames.
    pix_ce = 1'b1;
    repeat (1700) @(negedge clk);

    // pix_ce every second clk.
    repeat (400) @(negedge clk) pix_ce = ~pix_ce;
    pix_ce = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a line, then a fresh scan.
    pix_ce = 1'b1;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);

    pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
